// File: rtl/ysyx_23060077_riscv_lsu.sv
// Load/store stage: one instruction in flight, single-outstanding memory port,
// byte-lane steering, load extension and misalignment trapping.
//
// state  | meaning
// S_IDLE | ready for a new instruction
// S_REQ  | memory request presented, waiting for mem_req_ready
// S_WAIT | request accepted, waiting for mem_rsp_valid
// S_DONE | writeback result presented, waiting for out_ready
module ysyx_23060077_riscv_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_exu_result,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [2:0]            in_funct3,
  input  logic                  in_mem_ren,
  input  logic                  in_mem_wen,
  input  logic                  in_rd_wen,
  input  logic [4:0]            in_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_rd_wen,
  output logic [4:0]            out_rd,
  output logic                  out_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  load_q, load_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_wen_q, req_wen_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]            req_wstrb_q, req_wstrb_d;
  logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_rd_wen_q, out_rd_wen_d;
  logic [4:0]            out_rd_q, out_rd_d;
  logic                  out_misalign_q, out_misalign_d;

  logic [1:0]            in_off;
  logic                  in_is_mem;
  logic                  in_misalign;
  logic [3:0]            in_strb_base;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [DATA_WIDTH-1:0] rsp_shift;
  logic [DATA_WIDTH-1:0] load_data;

  assign in_off    = in_exu_result[1:0];
  assign in_is_mem = in_mem_ren | in_mem_wen;
  assign in_wdata  = in_src2 << {in_off, 3'b000};
  assign rsp_shift = mem_rsp_rdata >> {off_q, 3'b000};

  // Access size decode: misalignment check and unshifted strobe pattern.
  always_comb begin
    in_misalign  = 1'b0;
    in_strb_base = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        in_misalign  = 1'b0;
        in_strb_base = 4'b0001;
      end
      2'b01: begin
        in_misalign  = in_off[0];
        in_strb_base = 4'b0011;
      end
      default: begin
        in_misalign  = |in_off;
        in_strb_base = 4'b1111;
      end
    endcase
    in_misalign = in_misalign & in_is_mem;
  end

  // Extract the addressed lane from the read word and extend it to full width.
  always_comb begin
    load_data = rsp_shift;
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){rsp_shift[7]}}, rsp_shift[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){rsp_shift[15]}}, rsp_shift[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rsp_shift[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rsp_shift[15:0]};
      default: load_data = rsp_shift;
    endcase
  end

  // Next-state and datapath capture; everything holds unless a transition updates it.
  always_comb begin
    state_d        = state_q;
    off_d          = off_q;
    funct3_d       = funct3_q;
    load_d         = load_q;
    req_addr_d     = req_addr_q;
    req_wen_d      = req_wen_q;
    req_wdata_d    = req_wdata_q;
    req_wstrb_d    = req_wstrb_q;
    out_pc_d       = out_pc_q;
    out_data_d     = out_data_q;
    out_rd_wen_d   = out_rd_wen_q;
    out_rd_d       = out_rd_q;
    out_misalign_d = out_misalign_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          off_d          = in_off;
          funct3_d       = in_funct3;
          // Both enables high behaves as a store.
          load_d         = in_mem_ren & ~in_mem_wen;
          req_addr_d     = {in_exu_result[ADDR_WIDTH-1:2], 2'b00};
          req_wen_d      = in_mem_wen;
          req_wdata_d    = in_mem_wen ? in_wdata : '0;
          req_wstrb_d    = in_mem_wen ? (in_strb_base << in_off) : 4'b0000;
          out_pc_d       = in_pc;
          out_rd_d       = in_rd;
          out_misalign_d = in_misalign;
          if (!in_is_mem) begin
            out_data_d   = in_exu_result;
            out_rd_wen_d = in_rd_wen;
            state_d      = S_DONE;
          end else if (in_misalign) begin
            out_data_d   = '0;
            out_rd_wen_d = 1'b0;
            state_d      = S_DONE;
          end else begin
            out_data_d   = '0;
            out_rd_wen_d = in_rd_wen;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          out_data_d = load_q ? load_data : '0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured fields; reset clears everything so a late response finds IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      off_q          <= 2'b00;
      funct3_q       <= 3'b000;
      load_q         <= 1'b0;
      req_addr_q     <= '0;
      req_wen_q      <= 1'b0;
      req_wdata_q    <= '0;
      req_wstrb_q    <= 4'b0000;
      out_pc_q       <= '0;
      out_data_q     <= '0;
      out_rd_wen_q   <= 1'b0;
      out_rd_q       <= 5'd0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      off_q          <= off_d;
      funct3_q       <= funct3_d;
      load_q         <= load_d;
      req_addr_q     <= req_addr_d;
      req_wen_q      <= req_wen_d;
      req_wdata_q    <= req_wdata_d;
      req_wstrb_q    <= req_wstrb_d;
      out_pc_q       <= out_pc_d;
      out_data_q     <= out_data_d;
      out_rd_wen_q   <= out_rd_wen_d;
      out_rd_q       <= out_rd_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_DONE);
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign out_pc        = out_pc_q;
  assign out_data      = out_data_q;
  assign out_rd_wen    = out_rd_wen_q;
  assign out_rd        = out_rd_q;
  assign out_misalign  = out_misalign_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_lsu.sv
// Bench for the load/store stage: directed vector table, random ops against a
// byte-level reference model, and reset/late-response sequences.
module tb_ysyx_23060077_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_exu_result = '0;
  logic [31:0] in_src2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_mem_ren = 1'b0;
  logic        in_mem_wen = 1'b0;
  logic        in_rd_wen = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic        out_rd_wen;
  logic [4:0]  out_rd;
  logic        out_misalign;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_exu_result(in_exu_result), .in_src2(in_src2), .in_funct3(in_funct3),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_rd_wen(in_rd_wen), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_rd_wen(out_rd_wen), .out_rd(out_rd), .out_misalign(out_misalign)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc, exu, src2, rdata;
    logic [2:0]  f3;
    logic        ren, wen, rd_wen;
    logic [4:0]  rd;
    int          req_dly, rsp_dly, out_dly;
    logic        e_req, e_mis, e_rd_wen;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_wstrb;
  } vec_t;

  // Reference: works on individual bytes and integer arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     off;
    int     sz;
    bit     mem;
    longint val;
    r   = v;
    off = int'(v.exu[1:0]);
    sz  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    mem = v.ren || v.wen;
    r.e_mis    = mem && ((off % sz) != 0);
    r.e_req    = mem && !r.e_mis;
    r.e_addr   = v.exu - 32'(off);
    r.e_wstrb  = '0;
    r.e_wdata  = '0;
    if (v.wen) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= off) r.e_wdata[8*k +: 8] = v.src2[8*(k-off) +: 8];
        if (k >= off && k < off + sz) r.e_wstrb[k] = 1'b1;
      end
    end
    r.e_rd_wen = r.e_mis ? 1'b0 : v.rd_wen;
    if (!mem) r.e_data = v.exu;
    else if (r.e_mis || v.wen) r.e_data = '0;
    else begin
      val = 0;
      for (int b = sz - 1; b >= 0; b--) val = val * 256 + longint'(v.rdata[8*(off+b) +: 8]);
      if (!v.f3[2] && sz < 4 && val >= (longint'(1) << (8*sz - 1))) val = val - (longint'(1) << (8*sz));
      r.e_data = val[31:0];
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] exu, input logic [31:0] src2, input logic [2:0] f3,
                              input logic ren, input logic wen, input logic [31:0] rdata,
                              input int rq, input int od, input logic e_req, input logic e_mis,
                              input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                              input logic [31:0] e_wdata, input logic [31:0] e_data);
    vec_t v;
    v.pc = '0; v.rd = '0; v.rd_wen = 1'b1;
    v.exu = exu; v.src2 = src2; v.f3 = f3; v.ren = ren; v.wen = wen; v.rdata = rdata;
    v.req_dly = rq; v.rsp_dly = 0; v.out_dly = od;
    v.e_req = e_req; v.e_mis = e_mis; v.e_rd_wen = !e_mis;
    v.e_addr = e_addr; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata; v.e_data = e_data;
    return v;
  endfunction

  task automatic run_op(input vec_t v);
    int cyc;
    bit hs;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_pc = v.pc; in_exu_result = v.exu; in_src2 = v.src2; in_funct3 = v.f3;
    in_mem_ren = v.ren; in_mem_wen = v.wen; in_rd_wen = v.rd_wen; in_rd = v.rd; out_ready = 0;
    @(negedge clk);
    in_valid = 0; in_pc = $urandom; in_exu_result = $urandom; in_src2 = $urandom;
    in_funct3 = 3'($urandom); in_mem_ren = 1'($urandom); in_mem_wen = 1'($urandom);
    in_rd_wen = 1'($urandom); in_rd = 5'($urandom);
    chk("in_ready_busy", in_ready, 0);
    if (v.e_req) begin
      hs = 0; cyc = 0;
      while (!hs && cyc < 64) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_addr", mem_req_addr, v.e_addr);
        chk("req_wen", mem_req_wen, v.wen);
        chk("req_wstrb", mem_req_wstrb, v.e_wstrb);
        if (v.wen) chk("req_wdata", mem_req_wdata, v.e_wdata);
        chk("out_valid_in_req", out_valid, 0);
        chk("in_ready_in_req", in_ready, 0);
        hs = (cyc >= v.req_dly);
        mem_req_ready = hs;
        @(negedge clk);
        cyc++;
        mem_req_ready = 0;
      end
      if (!hs) chk("req_handshake_timeout", 0, 1);
      for (int i = 0; i < v.rsp_dly; i++) begin
        chk("out_valid_in_wait", out_valid, 0);
        @(negedge clk);
      end
      chk("req_valid_after_hs", mem_req_valid, 0);
      mem_rsp_valid = 1; mem_rsp_rdata = v.rdata;
      @(negedge clk);
      mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
    end else begin
      chk("no_req", mem_req_valid, 0);
    end
    for (int i = 0; i <= v.out_dly; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, v.e_data);
      chk("out_pc", out_pc, v.pc);
      chk("out_rd", out_rd, v.rd);
      chk("out_rd_wen", out_rd_wen, v.e_rd_wen);
      chk("out_misalign", out_misalign, v.e_mis);
      chk("in_ready_in_done", in_ready, 0);
      chk("req_valid_in_done", mem_req_valid, 0);
      out_ready = (i == v.out_dly);
      @(negedge clk);
    end
    out_ready = 0;
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_misalign", out_misalign, 0);
    chk("rst_out_rd_wen", out_rd_wen, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wstrb", mem_req_wstrb, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    tbl.push_back(mk(32'h0000_1234, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0000_1234));
    tbl.push_back(mk(32'h8000_0003, 0, 3'b000, 1, 0, 32'h8011_2233, 0, 0, 1, 0, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_FF80));
    tbl.push_back(mk(32'h8000_0003, 0, 3'b100, 1, 0, 32'h8011_2233, 0, 0, 1, 0, 32'h8000_0000, 4'b0000, 0, 32'h0000_0080));
    tbl.push_back(mk(32'h8000_0002, 32'h1234_ABCD, 3'b001, 0, 1, 0, 1, 0, 1, 0, 32'h8000_0000, 4'b1100, 32'hABCD_0000, 0));
    tbl.push_back(mk(32'h8000_0001, 0, 3'b010, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(32'h8000_0004, 0, 3'b010, 1, 0, 32'hDEAD_BEEF, 3, 2, 1, 0, 32'h8000_0004, 4'b0000, 0, 32'hDEAD_BEEF));
    tbl.push_back(mk(32'h8000_0002, 0, 3'b001, 1, 0, 32'h8011_2233, 0, 0, 1, 0, 32'h8000_0000, 4'b0000, 0, 32'hFFFF_8011));
    tbl.push_back(mk(32'h8000_0002, 0, 3'b101, 1, 0, 32'h8011_2233, 0, 0, 1, 0, 32'h8000_0000, 4'b0000, 0, 32'h0000_8011));
    tbl.push_back(mk(32'h0000_1001, 32'h1234_56AB, 3'b000, 0, 1, 0, 0, 0, 1, 0, 32'h0000_1000, 4'b0010, 32'h3456_AB00, 0));
    tbl.push_back(mk(32'h0000_2000, 32'hCAFE_F00D, 3'b010, 0, 1, 0, 2, 1, 1, 0, 32'h0000_2000, 4'b1111, 32'hCAFE_F00D, 0));
    tbl.push_back(mk(32'h0000_0003, 32'h1111_2222, 3'b001, 0, 1, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(32'h0000_0010, 32'h55AA_55AA, 3'b010, 1, 1, 32'hFFFF_FFFF, 0, 0, 1, 0, 32'h0000_0010, 4'b1111, 32'h55AA_55AA, 0));
    tbl.push_back(mk(32'h8000_0001, 0, 3'b001, 1, 0, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(32'h0000_0001, 0, 3'b000, 1, 0, 32'h00FF_7F00, 0, 0, 1, 0, 32'h0000_0000, 4'b0000, 0, 32'h0000_007F));
    tbl.push_back(mk(32'h0000_0002, 0, 3'b000, 1, 0, 32'h00FF_7F00, 0, 0, 1, 0, 32'h0000_0000, 4'b0000, 0, 32'hFFFF_FFFF));

    foreach (tbl[i]) begin
      v = tbl[i];
      v.pc = 32'h0000_0100 + 32'(i) * 4;
      v.rd = 5'(i + 1);
      run_op(v);
    end

    for (int n = 0; n < 200; n++) begin
      v.pc = $urandom; v.exu = $urandom; v.src2 = $urandom; v.rdata = $urandom;
      v.f3 = f3s[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0: begin v.ren = 0; v.wen = 0; end
        1: begin v.ren = 1; v.wen = 0; end
        2: begin v.ren = 0; v.wen = 1; end
        default: begin v.ren = 1'($urandom); v.wen = 1'($urandom); end
      endcase
      v.rd_wen = 1'($urandom); v.rd = 5'($urandom);
      v.req_dly = $urandom_range(0, 3); v.rsp_dly = $urandom_range(0, 3); v.out_dly = $urandom_range(0, 2);
      v = model(v);
      run_op(v);
    end

    // Reset while waiting for a response, then a stray late response.
    @(negedge clk);
    in_valid = 1; in_pc = 32'h0000_0400; in_exu_result = 32'h0000_0040; in_funct3 = 3'b010;
    in_mem_ren = 1; in_mem_wen = 0; in_rd_wen = 1; in_rd = 5'd7;
    @(negedge clk);
    in_valid = 0;
    chk("rstseq_req_valid", mem_req_valid, 1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("rstseq_in_wait", mem_req_valid, 0);
    chk("rstseq_in_wait_ready", in_ready, 0);
    #1 rst_n = 0;
    #1;
    chk("rstseq_async_in_ready", in_ready, 1);
    chk("rstseq_async_out_valid", out_valid, 0);
    chk("rstseq_async_req_valid", mem_req_valid, 0);
    @(negedge clk);
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 0;
    chk("late_rsp_out_valid", out_valid, 0);
    chk("late_rsp_in_ready", in_ready, 1);
    chk("late_rsp_req_valid", mem_req_valid, 0);
    chk("late_rsp_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    chk("late_rsp_still_idle", out_valid, 0);

    // Normal operation resumes after reset.
    v = model(mk(32'h0000_0044, 0, 3'b001, 1, 0, 32'hA5A5_8001, 1, 1, 0, 0, 0, 0, 0, 0));
    v.pc = 32'h0000_0500; v.rd = 5'd9;
    run_op(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
